// File: rtl/cpc_rom_loader.sv
// cpc_rom_loader
// Boot-time SRAM sequencer for the CPC core. Pulls ROM images from the control
// module as 32-bit words over a four-phase req/ack handshake and writes them
// byte by byte (MSB first) into the external SRAM. The CPC is held in reset and
// the SRAM port belongs to the loader until the last byte is written; after that
// the CPC memory path is passed straight through to the SRAM pins.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   host_reset            synchronous restart request (reload from scratch)
//   host_bootdata[31:0]   boot word, byte [31:24] written first
//   host_bootdata_ack     host has placed a valid word
//   host_bootdata_req     loader ready for a word (registered)
//   host_rom_initialised  loading complete, SRAM owned by the CPC
//   cpc_reset_n           CPC reset release, equals host_rom_initialised
//   cpu_addr/dout/we_n    CPC-side SRAM access, ignored while loading
//   sram_addr/dout        SRAM address and write data pins
//   sram_dout_en          drive enable for the SRAM data tristate
//   sram_we_n             SRAM write enable, active-low
`timescale 1ns/1ps

module cpc_rom_loader #(
    parameter int unsigned       ROM_BYTES = 49152,
    parameter int unsigned       ADDR_W    = 21,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_reset,
    input  logic [31:0]       host_bootdata,
    input  logic              host_bootdata_ack,
    output logic              host_bootdata_req,
    output logic              host_rom_initialised,
    output logic              cpc_reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    output logic              sram_dout_en,
    output logic              sram_we_n
);

    // One extra bit so a count equal to 2^ADDR_W is representable.
    localparam int unsigned       CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(ROM_BYTES - 1);

    typedef enum logic [2:0] {
        StReq,
        StSetup,
        StWe,
        StHold,
        StWaitAck,
        StDone
    } state_e;

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [1:0]         r_idx;
    logic [31:0]        r_word;
    logic               r_req;
    logic               r_rom_init;
    logic               r_we_n;
    logic               r_dout_en;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_dout;

    logic [CNT_W-1:0]   w_count_inc;
    logic [1:0]         w_idx_inc;

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_idx_inc   = r_idx + 2'd1;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        b = word[31:24];
        case (idx)
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Address and data are loaded on the edge entering SETUP, so they are
    // stable for the whole SETUP/WE/HOLD triplet around the 1-cycle we_n pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StReq;
            r_count    <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_req      <= 1'b0;
            r_rom_init <= 1'b0;
            r_we_n     <= 1'b1;
            r_dout_en  <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_dout     <= '0;
        end else if (host_reset) begin
            // REQ state implies req high, so it is asserted right away.
            r_state    <= StReq;
            r_count    <= '0;
            r_idx      <= '0;
            r_req      <= 1'b1;
            r_rom_init <= 1'b0;
            r_we_n     <= 1'b1;
            r_dout_en  <= 1'b0;
            r_addr     <= BASE_ADDR;
            r_dout     <= '0;
        end else begin
            case (r_state)
                StReq: begin
                    if (host_bootdata_ack) begin
                        r_word    <= host_bootdata;
                        r_idx     <= 2'd0;
                        r_req     <= 1'b0;
                        r_addr    <= BASE_ADDR + r_count[ADDR_W-1:0];
                        r_dout    <= host_bootdata[31:24];
                        r_dout_en <= 1'b1;
                        r_we_n    <= 1'b1;
                        r_state   <= StSetup;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                StSetup: begin
                    r_we_n  <= 1'b0;
                    r_state <= StWe;
                end
                StWe: begin
                    r_we_n  <= 1'b1;
                    r_state <= StHold;
                end
                StHold: begin
                    r_count <= w_count_inc;
                    if (r_count == LAST_CNT) begin
                        // Remaining bytes of a partial last word are dropped.
                        r_dout_en  <= 1'b0;
                        r_rom_init <= 1'b1;
                        r_state    <= StDone;
                    end else if (r_idx == 2'd3) begin
                        r_dout_en <= 1'b0;
                        r_state   <= StWaitAck;
                    end else begin
                        r_idx   <= w_idx_inc;
                        r_addr  <= BASE_ADDR + w_count_inc[ADDR_W-1:0];
                        r_dout  <= byte_sel(r_word, w_idx_inc);
                        r_state <= StSetup;
                    end
                end
                StWaitAck: begin
                    if (!host_bootdata_ack) begin
                        r_req   <= 1'b1;
                        r_state <= StReq;
                    end
                end
                StDone: begin
                    // Terminal; ack is deliberately ignored here.
                    r_req <= 1'b0;
                end
                default: begin
                    r_state <= StReq;
                end
            endcase
        end
    end

    assign host_bootdata_req    = r_req;
    assign host_rom_initialised = r_rom_init;
    assign cpc_reset_n          = r_rom_init;

    // Port ownership follows the registered rom_initialised flag.
    always_comb begin
        sram_addr    = r_addr;
        sram_dout    = r_dout;
        sram_we_n    = r_we_n;
        sram_dout_en = r_dout_en;
        if (r_rom_init) begin
            sram_addr    = cpu_addr;
            sram_dout    = cpu_dout;
            sram_we_n    = cpu_we_n;
            sram_dout_en = ~cpu_we_n;
        end
    end

endmodule
